// File: rtl/demux4_stream.sv
// Purpose: steer whole packets from one valid/ready stream to one of four valid/ready channels.
// Latency: one registered stage; a beat accepted in cycle t is presented in cycle t+1, 1 beat/cycle.
// Backpressure: in_ready follows the ready of the held beat's channel; a stalled channel stalls the input.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   in_valid/in_ready/in_data     input beat handshake and payload
//   in_sel                        destination channel, sampled on a packet's first beat only
//   in_last                       final beat of packet
//   out_valid[i]/out_ready[i]     per-channel handshake
//   out_data0..out_data3          per-channel data, zero when the channel holds no beat
//   out_last[i]                   per-channel final-beat flag, zero when the channel holds no beat
//   pkt_cnt                       per-channel completed-packet counters, channel i at [i*CNT_W +: CNT_W]
module demux4_stream #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE-1:0]      in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_last,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [SIZE-1:0]      out_data0,
    output logic [SIZE-1:0]      out_data1,
    output logic [SIZE-1:0]      out_data2,
    output logic [SIZE-1:0]      out_data3,
    output logic [3:0]           out_last,
    output logic [4*CNT_W-1:0]   pkt_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_route_lock;
    logic [1:0]       r_route;
    logic [SIZE-1:0]  r_data;
    logic             r_last;
    logic             r_full;
    logic [CNT_W-1:0] r_cnt [4];

    logic             w_out_acc;
    logic             w_in_acc;
    logic [1:0]       w_beat_route;
    logic [3:0]       w_sel;

    // Only the channel the held beat is destined for can free the register,
    // so ready on any other channel never lets a new beat in.
    assign w_out_acc    = r_full && out_ready[r_route];
    assign in_ready     = !r_full || out_ready[r_route];
    assign w_in_acc     = in_valid && in_ready;
    // First beat of a packet steers by in_sel; later beats follow the lock.
    assign w_beat_route = (r_state == ST_IDLE) ? in_sel : r_route_lock;

    // Holding register and packet FSM. A simultaneous in/out accept reloads
    // the register with full kept high, giving full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_route_lock <= 2'd0;
            r_route      <= 2'd0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_full       <= 1'b0;
        end else if (w_in_acc) begin
            r_data  <= in_data;
            r_route <= w_beat_route;
            r_last  <= in_last;
            r_full  <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_route_lock <= in_sel;
                    if (!in_last) begin
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (in_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end else if (w_out_acc) begin
            r_full <= 1'b0;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        assign w_sel[g] = r_full && (r_route == 2'(g));

        // Count a packet when its last beat leaves on this channel; wraps freely.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[g] <= '0;
            end else if (w_out_acc && r_last && (r_route == 2'(g))) begin
                r_cnt[g] <= r_cnt[g] + CNT_W'(1);
            end
        end

        assign pkt_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    assign out_valid = w_sel;
    assign out_last  = w_sel & {4{r_last}};
    assign out_data0 = w_sel[0] ? r_data : '0;
    assign out_data1 = w_sel[1] ? r_data : '0;
    assign out_data2 = w_sel[2] ? r_data : '0;
    assign out_data3 = w_sel[3] ? r_data : '0;

endmodule

// File: tb/tb_demux4_stream.sv
// Purpose: self-checking bench for demux4_stream with a per-channel scoreboard.
// Latency: expects each accepted beat on its channel one cycle after acceptance.
// Backpressure: drives random and directed out_ready stalls and checks the input stalls.
module tb_demux4_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic [1:0]  in_sel = 2'd0;
    logic        in_last = 1'b0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'hF;
    logic [7:0]  out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_last;
    logic [31:0] pkt_cnt;

    demux4_stream #(.SIZE(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_last  (out_last),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] od [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {last, data} per channel, plus a reference packet-steering model.
    logic [8:0] sb_q [4][$];
    logic [7:0] model_cnt [4];
    logic       m_burst = 1'b0;
    logic [1:0] m_lock = 2'd0;
    logic       rand_on = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pkt_cnt[i*8 +: 8] !== model_cnt[i]) begin
                    errors++;
                    $display("FAIL pkt_cnt[%0d]: got %0d expected %0d", i, pkt_cnt[i*8 +: 8], model_cnt[i]);
                end
                if (!out_valid[i]) begin
                    checks++;
                    if (od[i] !== 8'd0 || out_last[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_gate ch%0d: got data %h last %b expected 00 0", i, od[i], out_last[i]);
                    end
                end else if (out_ready[i]) begin
                    checks++;
                    if (sb_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL spurious ch%0d: got data %h expected no beat", i, od[i]);
                    end else begin
                        logic [8:0] exp;
                        exp = sb_q[i].pop_front();
                        if ({out_last[i], od[i]} !== exp) begin
                            errors++;
                            $display("FAIL beat ch%0d: got %h expected %h", i, {out_last[i], od[i]}, exp);
                        end
                        if (exp[8]) model_cnt[i] = model_cnt[i] + 8'd1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                logic [1:0] rt;
                rt = m_burst ? m_lock : in_sel;
                sb_q[rt].push_back({in_last, in_data});
                if (!m_burst) m_lock = in_sel;
                m_burst = !in_last;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            sb_q[i].delete();
            model_cnt[i] = 8'd0;
        end
        m_burst = 1'b0;
        m_lock  = 2'd0;
    endtask

    task automatic apply_reset();
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'hF;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Holds a beat until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [1:0] s, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready %b expected 1 within 100 cycles", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 4'b0 || out_last !== 4'b0 || pkt_cnt !== 32'd0 || in_ready !== 1'b1 ||
            od[0] !== 8'd0 || od[1] !== 8'd0 || od[2] !== 8'd0 || od[3] !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got valid %b last %b cnt %h rdy %b expected 0 0 0 1",
                     out_valid, out_last, pkt_cnt, in_ready);
        end
    endtask

    task automatic test_single();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ev;
            logic [7:0] ed;
            ev = 4'b0001 << i;
            ed = 8'h11 * 8'(i + 1);
            send(2'(i), ed, 1'b1);
            checks++;
            if (out_valid !== ev || od[i] !== ed || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single ch%0d: got valid %b data %h rdy %b expected %b %h 1",
                         i, out_valid, od[i], in_ready, ev, ed);
            end
        end
        idle(2);
        checks++;
        if (pkt_cnt !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL single_cnt: got %h expected 01010101", pkt_cnt);
        end
    endtask

    task automatic test_burst();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            logic [3:0] el;
            el = (k == 3) ? 4'b0100 : 4'b0000;
            send((k == 0) ? 2'd2 : 2'd1, 8'hA0 + 8'(k), (k == 3));
            checks++;
            if (out_valid !== 4'b0100 || out_data2 !== 8'hA0 + 8'(k) || out_last !== el) begin
                errors++;
                $display("FAIL burst beat%0d: got valid %b data %h last %b expected 0100 %h %b",
                         k, out_valid, out_data2, out_last, 8'hA0 + 8'(k), el);
            end
        end
        idle(2);
        checks++;
        if (pkt_cnt !== {8'd0, 8'd1, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL burst_cnt: got %h expected 00010000", pkt_cnt);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 8'hB0;
        in_last   = 1'b0;
        @(posedge clk);
        #1 in_data = 8'hB1;
        in_sel = 2'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data1 !== 8'hB0) begin
                errors++;
                $display("FAIL stall cyc%0d: got rdy %b valid %b data %h expected 0 0010 b0",
                         k, in_ready, out_valid, out_data1);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 4'hF;
        @(posedge clk);
        #1 in_data = 8'hB2;
        in_last = 1'b1;
        checks++;
        if (out_data1 !== 8'hB1) begin
            errors++;
            $display("FAIL drain_b1: got %h expected b1", out_data1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (out_data1 !== 8'hB2 || out_last !== 4'b0010) begin
            errors++;
            $display("FAIL drain_b2: got %h last %b expected b2 0010", out_data1, out_last);
        end
        idle(2);
        checks++;
        if (pkt_cnt !== {8'd0, 8'd0, 8'd1, 8'd0} || sb_q[1].size() != 0) begin
            errors++;
            $display("FAIL bp_cnt: got %h pending %0d expected 00000100 0", pkt_cnt, sb_q[1].size());
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int n = 0; n < 257; n++) send(2'd3, 8'(n), 1'b1);
        idle(2);
        checks++;
        if (pkt_cnt !== {8'd1, 24'd0}) begin
            errors++;
            $display("FAIL wrap: got %h expected 01000000", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send(2'd0, 8'hC0, 1'b0);
        send(2'd0, 8'hC1, 1'b0);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 8'hC2;
        in_last  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0 || out_last !== 4'b0 || pkt_cnt !== 32'd0 ||
            od[0] !== 8'd0 || od[1] !== 8'd0 || od[2] !== 8'd0 || od[3] !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got valid %b last %b data0 %h expected 0 0 00", out_valid, out_last, od[0]);
        end
        in_valid = 1'b0;
        clear_model();
        idle(2);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_rdy: got %b expected 1", in_ready);
        end
        send(2'd3, 8'h5A, 1'b1);
        checks++;
        if (out_valid !== 4'b1000 || out_data3 !== 8'h5A) begin
            errors++;
            $display("FAIL new_pkt: got valid %b data %h expected 1000 5a", out_valid, out_data3);
        end
        idle(2);
        checks++;
        if (pkt_cnt !== {8'd1, 24'd0}) begin
            errors++;
            $display("FAIL reset_mid_cnt: got %h expected 01000000", pkt_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1 out_ready = 4'($urandom);
                end
            end
        join_none
        for (int n = 0; n < 10000; n++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) == 0) || (n == 9999));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        rand_on = 1'b0;
        repeat (2) @(posedge clk);
        #2 out_ready = 4'hF;
        idle(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sb_q[i].size() != 0) begin
                errors++;
                $display("FAIL random_drain ch%0d: got %0d pending expected 0", i, sb_q[i].size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) model_cnt[i] = 8'd0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
